// File: rtl/div_sqrt_operand_prep.sv
// Operand preparation for the divide/square-root iteration unit: unpack, normalise subnormals, resolve special cases.
// Optional macro DIV_SQRT_PREP_FTZ_EN flushes subnormal inputs to signed zero at decode.
module div_sqrt_operand_prep #(
    parameter int unsigned MANT_W        = 53,
    parameter int unsigned EXP_W         = 13,
    parameter int unsigned SHIFT_PER_CYC = 8
) (
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    input  logic              In_valid_SI,
    output logic              In_ready_SO,
    input  logic [63:0]       Operand_a_DI,
    input  logic [63:0]       Operand_b_DI,
    input  logic              Sqrt_SI,
    input  logic [1:0]        Format_sel_SI,
    input  logic [2:0]        RM_SI,
    output logic              Out_valid_SO,
    input  logic              Out_ready_SI,
    output logic              Sign_a_DO,
    output logic              Sign_b_DO,
    output logic [EXP_W-1:0]  Exp_a_DO,
    output logic [EXP_W-1:0]  Exp_b_DO,
    output logic [MANT_W-1:0] Mant_a_DO,
    output logic [MANT_W-1:0] Mant_b_DO,
    output logic              Special_SO,
    output logic [63:0]       Special_result_DO,
    output logic [1:0]        Exc_flags_DO,
    output logic              Sqrt_SO,
    output logic [1:0]        Format_sel_SO,
    output logic [2:0]        RM_SO
);
    localparam int unsigned SHW = $clog2(SHIFT_PER_CYC + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_NORM, ST_OUT} state_t;
    typedef enum logic [1:0] {K_ZERO, K_INF, K_NAN} kind_t;

    state_t state_reg, state_next;

    logic [1:0][63:0]   opnd;
    logic [1:0]         dec_sign, dec_zero, dec_inf, dec_nan, dec_snan, dec_sub;
    logic [EXP_W-1:0]   dec_exp  [2];
    logic [MANT_W-1:0]  dec_mant [2];
    logic [EXP_W-1:0]   bias;
    logic [10:0]        e_max;

    assign opnd = {Operand_b_DI, Operand_a_DI};

    always_comb begin
        bias  = EXP_W'(127);
        e_max = 11'h0FF;
        case (Format_sel_SI)
            2'b01: begin bias = EXP_W'(1023); e_max = 11'h7FF; end
            2'b10: begin bias = EXP_W'(15);   e_max = 11'h01F; end
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dec
            logic [10:0] e_fld;
            logic [51:0] f_fld;
            logic        s_bit;
            logic        e_zero, e_ones, f_zero;
            logic [52:0] m53;

            // Fraction is left-aligned into a 52-bit field so every format shares one datapath
            always_comb begin
                s_bit = opnd[gi][15];
                e_fld = '0;
                f_fld = '0;
                case (Format_sel_SI)
                    2'b00: begin
                        s_bit = opnd[gi][31];
                        e_fld = {3'b0, opnd[gi][30:23]};
                        f_fld = {opnd[gi][22:0], 29'b0};
                    end
                    2'b01: begin
                        s_bit = opnd[gi][63];
                        e_fld = opnd[gi][62:52];
                        f_fld = opnd[gi][51:0];
                    end
                    2'b10: begin
                        e_fld = {6'b0, opnd[gi][14:10]};
                        f_fld = {opnd[gi][9:0], 42'b0};
                    end
                    default: begin
                        e_fld = {3'b0, opnd[gi][14:7]};
                        f_fld = {opnd[gi][6:0], 45'b0};
                    end
                endcase
            end

            assign e_zero         = (e_fld == 11'd0);
            assign e_ones         = (e_fld == e_max);
            assign f_zero         = (f_fld == 52'd0);
            assign dec_sign[gi]   = s_bit;
            assign dec_nan[gi]    = e_ones & ~f_zero;
            assign dec_snan[gi]   = e_ones & ~f_zero & ~f_fld[51];
            assign dec_inf[gi]    = e_ones & f_zero;
`ifdef DIV_SQRT_PREP_FTZ_EN
            assign dec_zero[gi]   = e_zero;
            assign dec_sub[gi]    = 1'b0;
            assign m53            = e_zero ? 53'd0 : {1'b1, f_fld};
`else
            assign dec_zero[gi]   = e_zero & f_zero;
            assign dec_sub[gi]    = e_zero & ~f_zero;
            assign m53            = {~e_zero, f_fld};
`endif
            assign dec_exp[gi]    = (e_zero ? EXP_W'(1) : {{(EXP_W-11){1'b0}}, e_fld}) - bias;
            assign dec_mant[gi]   = MANT_W'(m53) << (MANT_W - 53);
        end
    endgenerate

    // Special-case resolution; priority order matters (NaN first, zero before sign for sqrt)
    logic  spec_hit, spec_sign, spec_nv, spec_dz;
    kind_t spec_kind;

    always_comb begin
        spec_hit  = 1'b0;
        spec_kind = K_ZERO;
        spec_sign = dec_sign[0] ^ dec_sign[1];
        spec_nv   = 1'b0;
        spec_dz   = 1'b0;
        if (Sqrt_SI) begin
            spec_sign = dec_sign[0];
            if (dec_nan[0]) begin
                spec_hit = 1'b1; spec_kind = K_NAN; spec_nv = dec_snan[0];
            end else if (dec_zero[0]) begin
                spec_hit = 1'b1; spec_kind = K_ZERO;
            end else if (dec_sign[0]) begin
                spec_hit = 1'b1; spec_kind = K_NAN; spec_nv = 1'b1;
            end else if (dec_inf[0]) begin
                spec_hit = 1'b1; spec_kind = K_INF;
            end
        end else begin
            if (|dec_nan) begin
                spec_hit = 1'b1; spec_kind = K_NAN; spec_nv = |dec_snan;
            end else if ((dec_zero[0] & dec_zero[1]) | (dec_inf[0] & dec_inf[1])) begin
                spec_hit = 1'b1; spec_kind = K_NAN; spec_nv = 1'b1;
            end else if (dec_zero[1]) begin
                spec_hit = 1'b1; spec_kind = K_INF; spec_dz = 1'b1;
            end else if (dec_inf[0]) begin
                spec_hit = 1'b1; spec_kind = K_INF;
            end else if (dec_inf[1] | dec_zero[0]) begin
                spec_hit = 1'b1; spec_kind = K_ZERO;
            end
        end
    end

    logic [63:0] qnan_val, inf_val, sbit_val, spec_res;

    always_comb begin
        qnan_val = 64'h7FC0_0000;
        inf_val  = 64'h7F80_0000;
        sbit_val = 64'h8000_0000;
        case (Format_sel_SI)
            2'b01: begin
                qnan_val = 64'h7FF8_0000_0000_0000;
                inf_val  = 64'h7FF0_0000_0000_0000;
                sbit_val = 64'h8000_0000_0000_0000;
            end
            2'b10: begin qnan_val = 64'h7E00; inf_val = 64'h7C00; sbit_val = 64'h8000; end
            2'b11: begin qnan_val = 64'h7FC0; inf_val = 64'h7F80; sbit_val = 64'h8000; end
            default: ;
        endcase
        if (spec_kind == K_NAN) spec_res = qnan_val;
        else spec_res = ((spec_kind == K_INF) ? inf_val : 64'd0) | (spec_sign ? sbit_val : 64'd0);
    end

    logic need_norm, accept;
    assign need_norm = dec_sub[0] | (~Sqrt_SI & dec_sub[1]);
    assign accept    = (state_reg == ST_IDLE) & In_valid_SI;

    function automatic logic [SHW-1:0] lz_cap(input logic [MANT_W-1:0] m);
        lz_cap = SHW'(SHIFT_PER_CYC);
        for (int i = SHIFT_PER_CYC - 1; i >= 0; i--) begin
            if (m[MANT_W-1-i]) lz_cap = SHW'(i);
        end
    endfunction

    logic              sign_a_reg, sign_b_reg, special_reg, sqrt_reg;
    logic [EXP_W-1:0]  exp_a_reg, exp_b_reg, exp_a_next, exp_b_next;
    logic [MANT_W-1:0] mant_a_reg, mant_b_reg, mant_a_next, mant_b_next;
    logic [63:0]       result_reg;
    logic [1:0]        flags_reg, fmt_reg;
    logic [2:0]        rm_reg;
    logic [SHW-1:0]    lz_a, lz_b;
    logic              norm_done;

    // b is left untouched during a square root since it carries no meaning there
    always_comb begin
        lz_a        = lz_cap(mant_a_reg);
        lz_b        = sqrt_reg ? '0 : lz_cap(mant_b_reg);
        mant_a_next = mant_a_reg << lz_a;
        mant_b_next = mant_b_reg << lz_b;
        exp_a_next  = exp_a_reg - {{(EXP_W-SHW){1'b0}}, lz_a};
        exp_b_next  = exp_b_reg - {{(EXP_W-SHW){1'b0}}, lz_b};
        norm_done   = mant_a_next[MANT_W-1] & (sqrt_reg | mant_b_next[MANT_W-1]);
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) state_reg <= ST_IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (In_valid_SI) state_next = (!spec_hit && need_norm) ? ST_NORM : ST_OUT;
            ST_NORM: if (norm_done)   state_next = ST_OUT;
            ST_OUT:  if (Out_ready_SI) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        In_ready_SO  = 1'b0;
        Out_valid_SO = 1'b0;
        case (state_reg)
            ST_IDLE: In_ready_SO  = 1'b1;
            ST_OUT:  Out_valid_SO = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
            exp_a_reg   <= '0;
            exp_b_reg   <= '0;
            mant_a_reg  <= '0;
            mant_b_reg  <= '0;
            special_reg <= 1'b0;
            result_reg  <= '0;
            flags_reg   <= '0;
            sqrt_reg    <= 1'b0;
            fmt_reg     <= '0;
            rm_reg      <= '0;
        end else if (accept) begin
            sign_a_reg  <= dec_sign[0];
            sign_b_reg  <= dec_sign[1];
            exp_a_reg   <= dec_exp[0];
            exp_b_reg   <= dec_exp[1];
            mant_a_reg  <= dec_mant[0];
            mant_b_reg  <= dec_mant[1];
            special_reg <= spec_hit;
            result_reg  <= spec_hit ? spec_res : 64'd0;
            flags_reg   <= {spec_nv, spec_dz};
            sqrt_reg    <= Sqrt_SI;
            fmt_reg     <= Format_sel_SI;
            rm_reg      <= RM_SI;
        end else if (state_reg == ST_NORM) begin
            exp_a_reg   <= exp_a_next;
            exp_b_reg   <= exp_b_next;
            mant_a_reg  <= mant_a_next;
            mant_b_reg  <= mant_b_next;
        end
    end

    assign Sign_a_DO         = sign_a_reg;
    assign Sign_b_DO         = sign_b_reg;
    assign Exp_a_DO          = exp_a_reg;
    assign Exp_b_DO          = exp_b_reg;
    assign Mant_a_DO         = mant_a_reg;
    assign Mant_b_DO         = mant_b_reg;
    assign Special_SO        = special_reg;
    assign Special_result_DO = result_reg;
    assign Exc_flags_DO      = flags_reg;
    assign Sqrt_SO           = sqrt_reg;
    assign Format_sel_SO     = fmt_reg;
    assign RM_SO             = rm_reg;
endmodule
